// File: rtl/vga_sync.sv
// VGA timing generator: pixel tick, h/v counters, registered syncs.
// Optional frame_tick output enabled by defining VGA_FRAME_TICK_EN.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       tick_q;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_end;
  logic       v_end;
  logic       hsync_q;
  logic       vsync_q;

  // Pixel tick: toggles every clk, so it is high on alternate clks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= ~tick_q;
  end

  // Next counter values; they only move on a pixel tick.
  always_comb begin
    h_end  = (h_count == H_MAX);
    v_end  = (v_count == V_MAX);
    h_next = h_count;
    v_next = v_count;
    if (tick_q) begin
      if (h_end) begin
        h_next = '0;
        v_next = v_end ? '0 : v_count + 10'd1;
      end else begin
        h_next = h_count + 10'd1;
      end
    end
  end

  // Counters and syncs; syncs decode the next counters to stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      hsync_q <= ~((h_next >= HS_START) && (h_next <= HS_END));
      vsync_q <= ~((v_next >= VS_START) && (v_next <= VS_END));
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // One-clk pulse while the frame restarts at pixel (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= tick_q & h_end & v_end;
  end
`endif

  assign p_tick   = tick_q;
  assign pixel_x  = h_count;
  assign pixel_y  = v_count;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_count < H_VIS) && (v_count < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default timing plus a tiny-parameter instance.
// Reference model pushes expectations; each clk pops and compares.
module tb_vga_sync;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       hs_a, vs_a, vo_a, pt_a;
  logic [9:0] px_a, py_a;
  logic       hs_b, vs_b, vo_b, pt_b;
  logic [9:0] px_b, py_b;
  logic       fr_a, fr_b;

  vga_sync dut_a (
    .clk(clk), .reset(reset),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .p_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(fr_a)
`endif
  );

  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .p_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(fr_b)
`endif
  );

`ifndef VGA_FRAME_TICK_EN
  assign fr_a = 1'b0;
  assign fr_b = 1'b0;
`endif

  typedef struct packed {
    logic       pt;
    logic [9:0] ax, ay;
    logic       ahs, avs, avo, afr;
    logic [9:0] bx, by;
    logic       bhs, bvs, bvo, bfr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int mt, ax, ay, bx, by;
  bit fa, fb;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.pt  = (mt != 0);
    e.ax  = 10'(ax);
    e.ay  = 10'(ay);
    e.ahs = !(ax >= 656 && ax <= 751);
    e.avs = !(ay >= 490 && ay <= 491);
    e.avo = (ax < 640) && (ay < 480);
    e.afr = fa;
    e.bx  = 10'(bx);
    e.by  = 10'(by);
    e.bhs = !(bx >= 9 && bx <= 10);
    e.bvs = !(by == 5);
    e.bvo = (bx < 8) && (by < 4);
    e.bfr = fb;
    return e;
  endfunction

  task automatic model_zero();
    mt = 0; ax = 0; ay = 0; bx = 0; by = 0; fa = 0; fb = 0;
  endtask

  task automatic model_edge();
    bit wa, wb;
    if (reset) begin
      model_zero();
    end else begin
      fa = 0; fb = 0;
      if (mt != 0) begin
        wa = (ax == 799);
        fa = wa && (ay == 524);
        ax = wa ? 0 : ax + 1;
        if (wa) ay = (ay == 524) ? 0 : ay + 1;
        wb = (bx == 11);
        fb = wb && (by == 6);
        bx = wb ? 0 : bx + 1;
        if (wb) by = (by == 6) ? 0 : by + 1;
      end
      mt = (mt != 0) ? 0 : 1;
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = q.pop_front();
    check("p_tick",  32'(pt_a), 32'(e.pt));
    check("p_tick_b", 32'(pt_b), 32'(e.pt));
    check("pixel_x", 32'(px_a), 32'(e.ax));
    check("pixel_y", 32'(py_a), 32'(e.ay));
    check("hsync",   32'(hs_a), 32'(e.ahs));
    check("vsync",   32'(vs_a), 32'(e.avs));
    check("video_on", 32'(vo_a), 32'(e.avo));
    check("pixel_x_b", 32'(px_b), 32'(e.bx));
    check("pixel_y_b", 32'(py_b), 32'(e.by));
    check("hsync_b", 32'(hs_b), 32'(e.bhs));
    check("vsync_b", 32'(vs_b), 32'(e.bvs));
    check("video_on_b", 32'(vo_b), 32'(e.bvo));
`ifdef VGA_FRAME_TICK_EN
    check("frame_tick", 32'(fr_a), 32'(e.afr));
    check("frame_tick_b", 32'(fr_b), 32'(e.bfr));
`endif
  endtask

  task automatic step();
    model_edge();
    q.push_back(predict());
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) model_zero();
    q.push_back(predict());
    #1;
    compare_head();
  endtask

  initial begin
    int hcnt, first_hs, vocnt, first_vo;
    int bhcnt, bvcnt, first_bvy, blines, bpts, bfr_cnt;
    int prev_bx, prev_by, n;
    model_zero();
    repeat (3) step();
    check("rst_hsync", 32'(hs_a), 32'd1);
    check("rst_vsync", 32'(vs_a), 32'd1);
    check("rst_video_on", 32'(vo_a), 32'd1);
    check("rst_p_tick", 32'(pt_a), 32'd0);
    check("rst_pixel_x", 32'(px_a), 32'd0);

    set_reset(1'b0);
    hcnt = 0; first_hs = -1; vocnt = 0; first_vo = -1;
    bhcnt = 0; bvcnt = 0; first_bvy = -1; blines = 0;
    bpts = 0; bfr_cnt = 0; prev_bx = 0; prev_by = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (i == 0) begin
        check("first_tick", 32'(pt_a), 32'd1);
        check("first_px", 32'(px_a), 32'd0);
      end
      if (i == 1) begin
        check("second_tick", 32'(pt_a), 32'd0);
        check("px_step", 32'(px_a), 32'd1);
      end
      if (pt_a) begin
        if (!hs_a) begin
          hcnt++;
          if (first_hs < 0) first_hs = int'(px_a);
        end
        if (!vo_a) begin
          vocnt++;
          if (first_vo < 0) first_vo = int'(px_a);
        end
      end
      if (i < 168) begin
        if (fr_b) begin
          bfr_cnt++;
          check("ftick_pos_x", 32'(px_b), 32'd0);
          check("ftick_pos_y", 32'(py_b), 32'd0);
        end
        if (pt_b) begin
          bpts++;
          if (!hs_b) bhcnt++;
          if (!vs_b) begin
            bvcnt++;
            if (first_bvy < 0) first_bvy = int'(py_b);
          end
          if (px_b == 0) blines++;
          if (i > 0 && px_b == 0 && prev_bx != 0 && py_b == 0)
            check("b_vwrap_prev_y", 32'(prev_by), 32'd6);
          prev_bx = int'(px_b);
          prev_by = int'(py_b);
        end
      end
      if (i == 168) begin
        check("b_frame_ret_x", 32'(px_b), 32'd0);
        check("b_frame_ret_y", 32'(py_b), 32'd0);
        check("b_frame_ret_pt", 32'(pt_b), 32'd1);
      end
    end
    check("line_hsync_len", 32'(hcnt), 32'd96);
    check("line_hsync_start", 32'(first_hs), 32'd656);
    check("line_blank_len", 32'(vocnt), 32'd160);
    check("line_blank_start", 32'(first_vo), 32'd640);
    check("line_end_x", 32'(px_a), 32'd0);
    check("line_end_y", 32'(py_a), 32'd1);
    check("b_frame_pticks", 32'(bpts), 32'd84);
    check("b_lines", 32'(blines), 32'd7);
    check("b_hsync_len", 32'(bhcnt), 32'd14);
    check("b_vsync_len", 32'(bvcnt), 32'd12);
    check("b_vsync_line", 32'(first_bvy), 32'd5);
`ifdef VGA_FRAME_TICK_EN
    check("b_frame_ticks", 32'(bfr_cnt), 32'd1);
`endif

    n = 0;
    while (px_a != 10'd700 && n < 3000) begin
      step();
      n++;
    end
    check("reach_700_timeout", 32'(n < 3000), 32'd1);
    check("hsync_low_at_700", 32'(hs_a), 32'd0);
    set_reset(1'b1);
    check("mid_rst_hsync", 32'(hs_a), 32'd1);
    check("mid_rst_px", 32'(px_a), 32'd0);
    check("mid_rst_py", 32'(py_a), 32'd0);
    repeat (2) step();
    set_reset(1'b0);
    step();
    check("resume_px0", 32'(px_a), 32'd0);
    step();
    check("resume_px1", 32'(px_a), 32'd1);

    n = 0;
    while (!(px_b == 10'd9 && py_b == 10'd3) && n < 500) begin
      step();
      n++;
    end
    check("reach_b_timeout", 32'(n < 500), 32'd1);
    check("b_hsync_low", 32'(hs_b), 32'd0);
    set_reset(1'b1);
    check("b_rst_hsync", 32'(hs_b), 32'd1);
    check("b_rst_px", 32'(px_b), 32'd0);
    check("b_rst_py", 32'(py_b), 32'd0);
    step();
    set_reset(1'b0);
    repeat (2) step();
    check("b_resume_px1", 32'(px_b), 32'd1);
    check("b_resume_py0", 32'(py_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
